load_store_unit: RTL and testbench

//  Sits between the CPU execute stage and the byte-addressed data memory (32-bit port, 4 byte-lane

---
 rtl/load_store_unit_if.sv | 36 +++
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// master: CPU + memory side; slave: load_store_unit.
interface load_store_unit_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] daddr;
  logic [31:0]   dwdata;
  logic [3:0]    we;
  logic [31:0]   drdata;

  modport master (
    output req_valid, req_store, req_size,
    output req_unsigned, req_addr, req_wdata,
    output drdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_err, daddr, dwdata, we
  );

  modport slave (
    input  req_valid, req_store, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  drdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_err, daddr, dwdata, we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, lane steering, sign/zero extend.
// Ports: clk, rst (async high), bus (slave). Macro MISALIGN_SPLIT_EN enables split.
module load_store_unit #(
  parameter int AW = 32
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

`ifdef MISALIGN_SPLIT_EN
  localparam int BMW = 8;
  localparam int WW  = 64;
`else
  localparam int BMW = 4;
  localparam int WW  = 32;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ACC1,
`ifdef MISALIGN_SPLIT_EN
    ACC2,
`endif
    DONE
  } state_t;

  state_t state_q, state_d;

  logic          store_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rlo_q;
`ifdef MISALIGN_SPLIT_EN
  logic [31:0]   rhi_q;
`endif

  function automatic logic split_of(
    input logic [1:0] sz,
    input logic [1:0] of
  );
    logic [2:0] n;
    unique case (1'b1)
      (sz == 2'b00): n = 3'd1;
      (sz == 2'b01): n = 3'd2;
      default:       n = 3'd4;
    endcase
    return ({1'b0, of} + n) > 3'd4;
  endfunction

  logic           accept;
  logic [1:0]     off;
  logic           split;
  logic [3:0]     mask;
  logic [BMW-1:0] bm;
  logic [WW-1:0]  wide;
  logic [AW-1:0]  base;
  logic [63:0]    rd64;
  logic [31:0]    sh;
  logic [31:0]    ld;

  assign accept = bus.req_valid && (state_q == IDLE);
  assign off    = addr_q[1:0];
  assign split  = split_of(size_q, off);
  assign base   = {addr_q[AW-1:2], 2'b00};

  always_comb begin
    mask = 4'hF;
    unique case (1'b1)
      (size_q == 2'b00): mask = 4'h1;
      (size_q == 2'b01): mask = 4'h3;
      default:           mask = 4'hF;
    endcase
  end

  assign bm   = BMW'(mask) << off;
  assign wide = WW'(wdata_q) << {off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
  assign rd64 = {rhi_q, rlo_q};
`else
  assign rd64 = {32'b0, rlo_q};
`endif
  assign sh = 32'(rd64 >> {off, 3'b000});

  always_comb begin
    ld = sh;
    unique case (1'b1)
      (size_q == 2'b00):
        ld = uns_q ? {24'b0, sh[7:0]}
                   : {{24{sh[7]}}, sh[7:0]};
      (size_q == 2'b01):
        ld = uns_q ? {16'b0, sh[15:0]}
                   : {{16{sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
`ifdef MISALIGN_SPLIT_EN
          state_d = ACC1;
`else
          // no split support: misaligned goes straight to error
          state_d = split_of(bus.req_size, bus.req_addr[1:0])
                    ? DONE : ACC1;
`endif
        end
      end
`ifdef MISALIGN_SPLIT_EN
      ACC1:    state_d = split ? ACC2 : DONE;
      ACC2:    state_d = DONE;
`else
      ACC1:    state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      rhi_q   <= '0;
`endif
    end else begin
      if (accept) begin
        store_q <= bus.req_store;
        size_q  <= bus.req_size;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
`ifdef MISALIGN_SPLIT_EN
        rhi_q   <= '0;
`endif
      end
      if (state_q == ACC1) rlo_q <= bus.drdata;
`ifdef MISALIGN_SPLIT_EN
      if (state_q == ACC2) rhi_q <= bus.drdata;
`endif
    end
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = '0;
    bus.resp_err   = 1'b0;
    bus.daddr      = '0;
    bus.dwdata     = '0;
    bus.we         = 4'b0000;
    unique case (state_q)
      IDLE: bus.req_ready = 1'b1;
      ACC1: begin
        bus.daddr  = base;
        bus.dwdata = wide[31:0];
        bus.we     = store_q ? bm[3:0] : 4'b0000;
      end
`ifdef MISALIGN_SPLIT_EN
      ACC2: begin
        bus.daddr  = base + AW'(4);
        bus.dwdata = wide[63:32];
        bus.we     = store_q ? bm[7:4] : 4'b0000;
      end
`endif
      DONE: begin
        bus.resp_valid = 1'b1;
`ifdef MISALIGN_SPLIT_EN
        bus.resp_rdata = store_q ? 32'b0 : ld;
`else
        bus.resp_err   = split;
        bus.resp_rdata = (store_q || split) ? 32'b0 : ld;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte-lane memory.
// Covers aligned/misaligned loads/stores, extension, wrap and reset.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  load_store_unit_if #(.AW(32)) bus ();

  load_store_unit #(.AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];

  assign bus.drdata = mem[bus.daddr[7:2]];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.we[i])
        mem[bus.daddr[7:2]][8*i +: 8] <= bus.dwdata[8*i +: 8];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] a1_addr, a1_wd, a2_addr, a2_wd;
  logic [3:0]  a1_we, a2_we, any_we;

  task automatic xfer(
    input logic        st,
    input logic [1:0]  sz,
    input logic        un,
    input logic [31:0] a,
    input logic [31:0] wd
  );
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    bus.req_valid    = 1'b1;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = un;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    any_we = 4'b0000;
    a1_addr = '0; a1_wd = '0; a1_we = '0;
    a2_addr = '0; a2_wd = '0; a2_we = '0;
    for (int i = 1; i <= 6; i++) begin
      any_we |= bus.we;
      if (i == 1) begin
        a1_addr = bus.daddr; a1_wd = bus.dwdata; a1_we = bus.we;
      end
      if (i == 2) begin
        a2_addr = bus.daddr; a2_wd = bus.dwdata; a2_we = bus.we;
      end
      if (bus.resp_valid) begin
        lat = i;
        rdata = bus.resp_rdata;
        err = bus.resp_err;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (lat == 0) chk("timeout", 64'd0, 64'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_rv", 64'(bus.resp_valid), 64'd0);
    chk("rst_err", 64'(bus.resp_err), 64'd0);
    chk("rst_rd", 64'(bus.resp_rdata), 64'd0);
    chk("rst_addr", 64'(bus.daddr), 64'd0);
    chk("rst_wd", 64'(bus.dwdata), 64'd0);
    chk("rst_we", 64'(bus.we), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_lat", 64'(lat), 64'd2);
    chk("sw_addr", 64'(a1_addr), 64'h10);
    chk("sw_we", 64'(a1_we), 64'hF);
    chk("sw_wd", 64'(a1_wd), 64'hDEADBEEF);
    chk("sw_rd", 64'(rdata), 64'd0);
    chk("sw_err", 64'(err), 64'd0);

    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_lat", 64'(lat), 64'd2);
    chk("lw_rd", 64'(rdata), 64'hDEADBEEF);
    chk("lw_we", 64'(any_we), 64'd0);

    xfer(1'b1, 2'b00, 1'b0, 32'h13, 32'h80);
    chk("sb_we", 64'(a1_we), 64'h8);
    chk("sb_wd", 64'(a1_wd), 64'h80000000);
    chk("sb_addr", 64'(a1_addr), 64'h10);

    xfer(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk("lb", 64'(rdata), 64'hFFFFFF80);
    xfer(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk("lbu", 64'(rdata), 64'h00000080);

    xfer(1'b1, 2'b01, 1'b0, 32'h12, 32'h1234);
    chk("sh_we", 64'(a1_we), 64'hC);
    chk("sh_wd", 64'(a1_wd), 64'h12340000);

    xfer(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk("lh12", 64'(rdata), 64'h00001234);
    xfer(1'b0, 2'b01, 1'b1, 32'h11, 32'h0);
    chk("lhu11", 64'(rdata), 64'h000034BE);
    xfer(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
    chk("lh10", 64'(rdata), 64'hFFFFBEEF);
    xfer(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    chk("lhu10", 64'(rdata), 64'h0000BEEF);
    xfer(1'b0, 2'b11, 1'b1, 32'h10, 32'h0);
    chk("lw_sz3", 64'(rdata), 64'h1234BEEF);

`ifdef MISALIGN_SPLIT_EN
    xfer(1'b1, 2'b10, 1'b0, 32'h1D, 32'hAABBCCDD);
    chk("ssw_lat", 64'(lat), 64'd3);
    chk("ssw_a1", 64'(a1_addr), 64'h1C);
    chk("ssw_we1", 64'(a1_we), 64'hE);
    chk("ssw_wd1", 64'(a1_wd), 64'hBBCCDD00);
    chk("ssw_a2", 64'(a2_addr), 64'h20);
    chk("ssw_we2", 64'(a2_we), 64'h1);
    chk("ssw_wd2", 64'(a2_wd), 64'h000000AA);
    chk("ssw_err", 64'(err), 64'd0);

    xfer(1'b0, 2'b10, 1'b0, 32'h1D, 32'h0);
    chk("slw_lat", 64'(lat), 64'd3);
    chk("slw_rd", 64'(rdata), 64'hAABBCCDD);

    xfer(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h5566);
    chk("wrap_a1", 64'(a1_addr), 64'hFFFFFFFC);
    chk("wrap_we1", 64'(a1_we), 64'h8);
    chk("wrap_a2", 64'(a2_addr), 64'h0);
    chk("wrap_we2", 64'(a2_we), 64'h1);
    chk("wrap_wd2", 64'(a2_wd), 64'h55);
    xfer(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0);
    chk("wrap_ld", 64'(rdata), 64'h5566);

    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_store = 1'b1;
    bus.req_size = 2'b10;
    bus.req_addr = 32'h1D;
    bus.req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rs_acc2_we", 64'(bus.we), 64'h1);
    rst = 1'b1;
    #1;
    chk("rs_ready", 64'(bus.req_ready), 64'd1);
    chk("rs_we", 64'(bus.we), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rs_m20", 64'(mem[8]), 64'h000000AA);
    chk("rs_m1c", 64'(mem[7]), 64'h22334400);
`else
    xfer(1'b0, 2'b10, 1'b0, 32'h1D, 32'h0);
    chk("mis_lat", 64'(lat), 64'd1);
    chk("mis_err", 64'(err), 64'd1);
    chk("mis_rd", 64'(rdata), 64'd0);
    chk("mis_we", 64'(any_we), 64'd0);
    xfer(1'b1, 2'b10, 1'b0, 32'h1D, 32'hAABBCCDD);
    chk("miss_err", 64'(err), 64'd1);
    chk("miss_we", 64'(any_we), 64'd0);
    chk("miss_m1c", 64'(mem[7]), 64'd0);
    chk("miss_m20", 64'(mem[8]), 64'd0);
    xfer(1'b0, 2'b01, 1'b0, 32'h13, 32'h0);
    chk("mish_err", 64'(err), 64'd1);
    xfer(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("ok_err", 64'(err), 64'd0);
    chk("ok_rd", 64'(rdata), 64'h000000BE);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
